// File: rtl/univ_shift_register.sv
// ============================================================================
// Module   : univ_shift_register
// Brief    : Universal shift register. It supports parallel load, logical shift,
//            rotate and arithmetic shift, one bit per clock, and uses a
//            start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module univ_shift_register #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] d_in,
  input  logic             ser_l,
  input  logic             ser_r,
  output logic [WIDTH-1:0] out,
  output logic             ser_msb,
  output logic             ser_lsb,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] c_MODE_HOLD = 3'b000;
  localparam logic [2:0] c_MODE_LOAD = 3'b001;
  localparam logic [2:0] c_MODE_SHL  = 3'b010;
  localparam logic [2:0] c_MODE_SHR  = 3'b011;
  localparam logic [2:0] c_MODE_ROL  = 3'b100;
  localparam logic [2:0] c_MODE_ROR  = 3'b101;
  localparam logic [2:0] c_MODE_ASR  = 3'b110;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_next_state;
  logic [AMT_W-1:0] r_cnt, w_next_cnt;
  logic [2:0]       r_mode, w_next_mode;
  logic [WIDTH-1:0] r_out, w_next_out, w_shifted;
  logic             r_done, w_next_done;

  // Single-bit step for the latched mode. The serial fill bits are taken live.
  always_comb begin
    w_shifted = r_out;
    case (r_mode)
      c_MODE_SHL: w_shifted = {r_out[WIDTH-2:0], ser_l};
      c_MODE_SHR: w_shifted = {ser_r, r_out[WIDTH-1:1]};
      c_MODE_ROL: w_shifted = {r_out[WIDTH-2:0], r_out[WIDTH-1]};
      c_MODE_ROR: w_shifted = {r_out[0], r_out[WIDTH-1:1]};
      c_MODE_ASR: w_shifted = {r_out[WIDTH-1], r_out[WIDTH-1:1]};
      default:    w_shifted = r_out;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_mode  = r_mode;
    w_next_out   = r_out;
    w_next_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_mode = mode;
          case (mode)
            c_MODE_LOAD: begin
              w_next_out  = d_in;
              w_next_done = 1'b1;
            end
            c_MODE_SHL, c_MODE_SHR, c_MODE_ROL, c_MODE_ROR, c_MODE_ASR: begin
              if (amt == '0) begin
                w_next_done = 1'b1;
              end else begin
                w_next_state = S_SHIFT;
                w_next_cnt   = amt;
              end
            end
            default: w_next_done = 1'b1;  // HOLD and the reserved code
          endcase
        end
      end
      S_SHIFT: begin
        w_next_out = w_shifted;
        w_next_cnt = r_cnt - AMT_W'(1);
        if (r_cnt == AMT_W'(1)) begin
          w_next_state = S_IDLE;
          w_next_done  = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mode  <= c_MODE_HOLD;
      r_out   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_mode  <= w_next_mode;
      r_out   <= w_next_out;
      r_done  <= w_next_done;
    end
  end

  assign out     = r_out;
  assign ser_msb = r_out[WIDTH-1];
  assign ser_lsb = r_out[0];
  assign busy    = (r_state == S_SHIFT);
  assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_univ_shift_register.sv
// ============================================================================
// Module   : tb_univ_shift_register
// Brief    : Directed, table-driven self-checking bench for univ_shift_register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_univ_shift_register;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [2:0] mode = 3'b000;
  logic [3:0] amt = 4'd0;
  logic [7:0] d_in = 8'h00;
  logic       ser_l = 1'b0;
  logic       ser_r = 1'b0;
  logic [7:0] out;
  logic       ser_msb, ser_lsb, busy, done;

  int errors = 0;
  int checks = 0;

  univ_shift_register #(.WIDTH(8), .AMT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .amt(amt),
    .d_in(d_in), .ser_l(ser_l), .ser_r(ser_r), .out(out),
    .ser_msb(ser_msb), .ser_lsb(ser_lsb), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] mode;
    logic [3:0] amt;
    logic [7:0] din;
    logic       sl;
    logic       sr;
    logic [7:0] exp_out;
    int         exp_busy;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one operation and follow it to its done pulse.
  task automatic run_op(input logic [2:0] m, input logic [3:0] a, input logic [7:0] d,
                        input logic sl, input logic sr, output logic [7:0] o,
                        output int bcnt, output int dcnt, output bit ovl, output bit tmo);
    @(negedge clk);
    start = 1'b1; mode = m; amt = a; d_in = d; ser_l = sl; ser_r = sr;
    @(posedge clk); #1;
    start = 1'b0; mode = 3'b001; amt = 4'hF; d_in = 8'hFF;
    o = out; bcnt = 0; dcnt = 0; ovl = 1'b0; tmo = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (busy && done) ovl = 1'b1;
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        tmo = 1'b0;
        o = out;
        @(posedge clk); #1;
        if (done) dcnt++;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [7:0] o;
    int bcnt, dcnt;
    bit ovl, tmo;

    vecs[0]  = '{3'b001, 4'd0,  8'hA5, 1'b0, 1'b0, 8'hA5, 0};
    vecs[1]  = '{3'b010, 4'd3,  8'h00, 1'b1, 1'b0, 8'h2F, 3};
    vecs[2]  = '{3'b001, 4'd0,  8'h81, 1'b0, 1'b0, 8'h81, 0};
    vecs[3]  = '{3'b101, 4'd9,  8'h00, 1'b0, 1'b0, 8'hC0, 9};
    vecs[4]  = '{3'b001, 4'd0,  8'h90, 1'b0, 1'b0, 8'h90, 0};
    vecs[5]  = '{3'b110, 4'd2,  8'h00, 1'b0, 1'b0, 8'hE4, 2};
    vecs[6]  = '{3'b011, 4'd0,  8'h00, 1'b0, 1'b1, 8'hE4, 0};
    vecs[7]  = '{3'b000, 4'd5,  8'h33, 1'b0, 1'b0, 8'hE4, 0};
    vecs[8]  = '{3'b111, 4'd3,  8'h33, 1'b1, 1'b1, 8'hE4, 0};
    vecs[9]  = '{3'b100, 4'd1,  8'h00, 1'b0, 1'b0, 8'hC9, 1};
    vecs[10] = '{3'b011, 4'd4,  8'h00, 1'b0, 1'b0, 8'h0C, 4};
    vecs[11] = '{3'b010, 4'd15, 8'h00, 1'b1, 1'b0, 8'hFF, 15};
    vecs[12] = '{3'b001, 4'd0,  8'h80, 1'b0, 1'b0, 8'h80, 0};
    vecs[13] = '{3'b110, 4'd15, 8'h00, 1'b0, 1'b0, 8'hFF, 15};
    vecs[14] = '{3'b001, 4'd0,  8'h96, 1'b0, 1'b0, 8'h96, 0};
    vecs[15] = '{3'b100, 4'd8,  8'h00, 1'b0, 1'b0, 8'h96, 8};

    // Power-on reset state
    #12;
    chk("reset_out", 32'(out), 32'h00);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    @(negedge clk); reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].mode, vecs[i].amt, vecs[i].din, vecs[i].sl, vecs[i].sr, o, bcnt, dcnt, ovl, tmo);
      chk($sformatf("v%0d_out", i), 32'(o), 32'(vecs[i].exp_out));
      chk($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'(vecs[i].exp_busy));
      chk($sformatf("v%0d_done_pulses", i), 32'(dcnt), 32'd1);
      chk($sformatf("v%0d_overlap_or_timeout", i), 32'({ovl, tmo}), 32'd0);
      chk($sformatf("v%0d_ser_msb", i), 32'(ser_msb), 32'(vecs[i].exp_out[7]));
      chk($sformatf("v%0d_ser_lsb", i), 32'(ser_lsb), 32'(vecs[i].exp_out[0]));
    end

    // SHL step values from 8'hA5 with ser_l=1
    run_op(3'b001, 4'd0, 8'hA5, 1'b0, 1'b0, o, bcnt, dcnt, ovl, tmo);
    @(negedge clk);
    start = 1'b1; mode = 3'b010; amt = 4'd3; ser_l = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("shl_e0_out", 32'(out), 32'hA5);
    chk("shl_e0_busy", 32'(busy), 32'd1);
    @(posedge clk); #1; chk("shl_e1", 32'(out), 32'h4B);
    @(posedge clk); #1; chk("shl_e2", 32'(out), 32'h97);
    @(posedge clk); #1; chk("shl_e3", 32'(out), 32'h2F);
    chk("shl_e3_done", 32'({busy, done}), 32'b01);

    // Serial fill bit is sampled live at each shift edge
    run_op(3'b001, 4'd0, 8'h00, 1'b0, 1'b0, o, bcnt, dcnt, ovl, tmo);
    @(negedge clk);
    start = 1'b1; mode = 3'b010; amt = 4'd3; ser_l = 1'b0;
    @(posedge clk); #1; start = 1'b0; ser_l = 1'b1;
    @(posedge clk); #1; ser_l = 1'b0;
    @(posedge clk); #1; ser_l = 1'b1;
    @(posedge clk); #1;
    chk("live_ser_l", 32'(out), 32'h05);

    // start with LOAD during busy is ignored
    run_op(3'b001, 4'd0, 8'h81, 1'b0, 1'b0, o, bcnt, dcnt, ovl, tmo);
    @(negedge clk);
    start = 1'b1; mode = 3'b101; amt = 4'd9;
    @(posedge clk); #1; start = 1'b0;
    bcnt = 0; tmo = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (busy) bcnt++;
      if (done) begin tmo = 1'b0; break; end
      start = (i == 2); mode = 3'b001; d_in = 8'h00;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("busy_start_out", 32'(out), 32'hC0);
    chk("busy_start_cycles", 32'(bcnt), 32'd9);
    chk("busy_start_timeout", 32'(tmo), 32'd0);

    // Back-to-back: start held at the done cycle is accepted at once
    run_op(3'b001, 4'd0, 8'h11, 1'b0, 1'b0, o, bcnt, dcnt, ovl, tmo);
    @(negedge clk);
    start = 1'b1; mode = 3'b100; amt = 4'd2;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("b2b_first_done", 32'({busy, done}), 32'b01);
    chk("b2b_first_out", 32'(out), 32'h44);
    start = 1'b1; mode = 3'b001; d_in = 8'h3C;
    @(posedge clk); #1; start = 1'b0;
    chk("b2b_second_out", 32'(out), 32'h3C);
    chk("b2b_second_done", 32'({busy, done}), 32'b01);

    // Asynchronous reset mid-shift
    run_op(3'b001, 4'd0, 8'h5A, 1'b0, 1'b0, o, bcnt, dcnt, ovl, tmo);
    @(negedge clk);
    start = 1'b1; mode = 3'b010; amt = 4'd10; ser_l = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_out", 32'(out), 32'h00);
    chk("async_reset_busy", 32'(busy), 32'd0);
    chk("async_reset_done", 32'(done), 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle", 32'({busy, done}), 32'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
